imem_loader: RTL and testbench

- Host-side writer for the core's 8-bit-addressed, 32-bit-wide instruction memory; the fetch stage is the reader.
- Accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words.
- Writes the words to sequential instruction-memory addresses starting at 0.
- Holds the pipeline in reset (core_rst_o) from power-up and during a load; releases it only after a load completes successfully.

---
 rtl/imem_loader_pkg.sv | 10 +
 rtl/imem_loader_byte_packer.sv | 34 +++
 rtl/imem_loader.sv | 93 +++++++++
 tb/tb_imem_loader.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM encoding and byte-packing constants for the instruction-memory loader
package imem_loader_pkg;
   localparam int BYTES_PER_WORD = 4;
   localparam int IDX_W = $clog2(BYTES_PER_WORD);
   typedef logic [1:0] state_t;
   localparam state_t S_IDLE     = 2'd0;
   localparam state_t S_ASSEMBLE = 2'd1;
   localparam state_t S_WRITE    = 2'd2;
   localparam state_t S_DONE     = 2'd3;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: shifts accepted bytes little-endian into a word; ports: clk_i/rst_i, clr_i drops any partial word, accept_i/byte_i load a byte, word_o is the word including the current byte, full_o marks the last byte of a word
module byte_packer
   import imem_loader_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              accept_i,
   input  logic [7:0]        byte_i,
   output logic [DATA_W-1:0] word_o,
   output logic              full_o
);
   logic [DATA_W-1:0] sr;
   logic [IDX_W-1:0]  idx;
   // word_o already contains the byte being accepted, so the top can register a complete word on the 4th-byte edge
   always_comb begin
      word_o = {byte_i, sr[DATA_W-1:8]};
      full_o = accept_i && idx == IDX_W'(BYTES_PER_WORD - 1);
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sr  <= '0;
         idx <= '0;
      end else if (clr_i) begin
         sr  <= '0;
         idx <= '0;
      end else if (accept_i) begin
         sr  <= word_o;
         idx <= full_o ? '0 : idx + 1'b1;
      end
   end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a host byte stream into 32-bit words, writes them to instruction memory from address 0 and holds the core in reset until a load completes; ports: clk_i/rst_i, start_i/len_i/abort_i control, byte_valid_i/byte_data_i/byte_ready_o stream, imem_we_o/imem_addr_o/imem_wdata_o write port, core_rst_o/busy_o/done_o/err_o status
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W:0]   len_i,
   input  logic              abort_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_data_i,
   output logic              byte_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [DATA_W-1:0] imem_wdata_o,
   output logic              core_rst_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);
   state_t            state, nxt;
   logic [ADDR_W:0]   len, wcnt;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] word;
   logic              word_full, accept, active, go, kill;
   // byte_ready_o is high exactly in ASSEMBLE, so it doubles as the state decode for acceptance
   always_comb begin
      accept = byte_valid_i && byte_ready_o && !abort_i;
      active = state == S_ASSEMBLE || state == S_WRITE;
      go     = state == S_IDLE && start_i;
      kill   = active && abort_i;
      nxt    = S_IDLE;
      unique case (state)
         S_IDLE:     nxt = go ? (len_i == '0 ? S_DONE : S_ASSEMBLE) : S_IDLE;
         S_ASSEMBLE: nxt = abort_i ? S_IDLE : word_full ? S_WRITE : S_ASSEMBLE;
         S_WRITE:    nxt = abort_i ? S_IDLE : (wcnt + 1'b1 == len) ? S_DONE : S_ASSEMBLE;
         default:    nxt = S_IDLE;
      endcase
   end
   byte_packer #(.DATA_W(DATA_W)) u_packer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (go || kill),
      .accept_i (accept),
      .byte_i   (byte_data_i),
      .word_o   (word),
      .full_o   (word_full)
   );
   // Outputs are registered from the next-state decode so they line up with the state they describe
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         byte_ready_o <= 1'b0;
         imem_we_o    <= 1'b0;
         imem_addr_o  <= '0;
         imem_wdata_o <= '0;
         core_rst_o   <= 1'b1;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
         len          <= '0;
         wcnt         <= '0;
         waddr        <= '0;
      end else begin
         state        <= nxt;
         byte_ready_o <= nxt == S_ASSEMBLE;
         imem_we_o    <= nxt == S_WRITE;
         busy_o       <= nxt == S_ASSEMBLE || nxt == S_WRITE;
         done_o       <= nxt == S_DONE;
         if (word_full) begin
            imem_addr_o  <= waddr;
            imem_wdata_o <= word;
         end
         // waddr is ADDR_W wide, so the 256th word wraps it to 0 naturally
         if (state == S_WRITE) begin
            waddr <= waddr + 1'b1;
            wcnt  <= wcnt + 1'b1;
         end
         if (go) begin
            len        <= len_i;
            wcnt       <= '0;
            waddr      <= '0;
            err_o      <= 1'b0;
            core_rst_o <= 1'b1;
         end
         if (kill) err_o <= 1'b1;
         if (state == S_DONE) core_rst_o <= 1'b0;
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader
module tb_imem_loader;
   logic        clk_i = 0, rst_i = 1, start_i = 0, abort_i = 0, byte_valid_i = 0;
   logic [8:0]  len_i = '0;
   logic [7:0]  byte_data_i = '0;
   logic        byte_ready_o, imem_we_o, core_rst_o, busy_o, done_o, err_o;
   logic [7:0]  imem_addr_o;
   logic [31:0] imem_wdata_o;
   int          vectors = 0, miscompares = 0, done_seen = 0;
   logic [39:0] wr_q[$];
   logic [39:0] mon_exp;

   imem_loader dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .abort_i(abort_i),
      .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
      .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
      .core_rst_o(core_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write the DUT presents must match the oldest expected write
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (done_o) done_seen++;
         if (imem_we_o) begin
            if (wr_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr_o, imem_wdata_o);
            end else begin
               mon_exp = wr_q.pop_front();
               chk("write", {imem_addr_o, imem_wdata_o}, mon_exp);
               chk("ready_in_write", byte_ready_o, 0);
            end
         end
      end
   end

   task automatic send(input logic [7:0] b, input int gap);
      logic acc;
      int   n;
      byte_valid_i = 0;
      repeat (gap) @(negedge clk_i);
      byte_valid_i = 1;
      byte_data_i  = b;
      n = 0;
      do begin
         acc = byte_ready_o;
         @(negedge clk_i);
         n++;
      end while (!acc && n < 100);
      if (!acc) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout: got no ready expected ready within 100 cycles");
      end
   endtask

   task automatic start_load(input int len);
      start_i = 1;
      len_i   = 9'(len);
      @(negedge clk_i);
      start_i = 0;
   endtask

   // Reference model: word w holds bytes 4w..4w+3, lowest byte in the low bits
   task automatic push_words(input logic [7:0] b[$]);
      for (int w = 0; w < b.size() / 4; w++)
         wr_q.push_back({8'(w), b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]});
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      chk(name, done_o, 1);
   endtask

   initial begin
      logic [7:0] b[$];
      int d0;
      repeat (3) @(negedge clk_i);
      rst_i = 0;
      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         if (i == 9) begin
            chk("idle_core_rst", core_rst_o, 1);
            chk("idle_we", imem_we_o, 0);
            chk("idle_ready", byte_ready_o, 0);
         end
      end
      chk("idle_no_done", done_seen, 0);

      // len=2, valid held high
      b = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
      push_words(b);
      start_load(2);
      for (int i = 0; i < 8; i++) begin
         send(b[i], 0);
         if (i == 3) chk("write_latency", {imem_we_o, imem_addr_o, imem_wdata_o}, {1'b1, 8'h00, 32'h00100013});
      end
      byte_valid_i = 0;
      chk("last_write_cycle", imem_we_o, 1);
      @(negedge clk_i);
      chk("done_pulse", done_o, 1);
      @(negedge clk_i);
      chk("done_one_cycle", done_o, 0);
      chk("core_rst_release", core_rst_o, 0);
      chk("q_empty_2", wr_q.size(), 0);

      // len=1 with random gaps
      b = '{8'h11, 8'h22, 8'h33, 8'h44};
      push_words(b);
      start_load(1);
      chk("core_rst_reassert", core_rst_o, 1);
      for (int i = 0; i < 4; i++) send(b[i], $urandom_range(0, 3));
      byte_valid_i = 0;
      wait_done("done_len1");
      repeat (3) @(negedge clk_i);
      chk("q_empty_1", wr_q.size(), 0);

      // len=3 with abort after 6 bytes
      b = {};
      for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
      push_words(b);
      d0 = done_seen;
      start_load(3);
      for (int i = 0; i < 6; i++) send(b[i], $urandom_range(0, 1));
      byte_valid_i = 0;
      abort_i = 1;
      @(negedge clk_i);
      abort_i = 0;
      chk("abort_err", err_o, 1);
      chk("abort_core_rst", core_rst_o, 1);
      chk("abort_idle", {busy_o, byte_ready_o}, 0);
      repeat (5) @(negedge clk_i);
      chk("abort_no_done", done_seen, d0);
      chk("q_empty_abort", wr_q.size(), 0);

      // len=0: clears err, immediate done, no writes
      start_load(0);
      chk("start_clears_err", err_o, 0);
      chk("len0_done", done_o, 1);
      @(negedge clk_i);
      chk("len0_core_rst", core_rst_o, 0);

      // async reset mid-assemble
      start_load(2);
      send(8'hAA, 0);
      send(8'hBB, 0);
      byte_valid_i = 0;
      @(posedge clk_i);
      #2 rst_i = 1;
      #1;
      chk("arst_outputs", {byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, core_rst_o, busy_o, done_o, err_o},
          {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
      @(negedge clk_i);
      rst_i = 0;
      @(negedge clk_i);

      // Full 256-word load
      b = {};
      for (int i = 0; i < 1024; i++) b.push_back(8'($urandom));
      push_words(b);
      d0 = done_seen;
      start_load(256);
      for (int i = 0; i < 1024; i++) send(b[i], ($urandom_range(0, 7) == 0) ? 1 : 0);
      byte_valid_i = 0;
      wait_done("done_len256");
      @(negedge clk_i);
      chk("len256_core_rst", core_rst_o, 0);
      chk("len256_one_done", done_seen - d0, 1);
      chk("q_empty_256", wr_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
